// File: rtl/apb_master.sv
// apb_master: APB requester for two 8-bit slaves sharing one bus.
// It takes single read/write commands from a level-sensitive local request,
// runs each one through IDLE -> SETUP -> ACCESS, and decodes addr[8] to pick
// PSEL2 (1) or PSEL1 (0). It selects the matching PREADY/PRDATA, captures
// read data, and pulses done for one cycle when a transfer ends.
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase
// after TIMEOUT stalled cycles. The abort reports done together with err.
// Without the macro, ACCESS waits indefinitely and err stays 0.
module apb_master #(
  parameter int TIMEOUT = 15
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       req,
  input  logic       wr,
  input  logic [8:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       done,
  output logic       busy,
  output logic       err,
  output logic       PSEL1,
  output logic       PSEL2,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA1,
  input  logic [7:0] PRDATA2,
  input  logic       PREADY1,
  input  logic       PREADY2
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic       sel2_r;      // latched addr[8] of the transfer in flight
  logic       sel2_s;
  logic       accept_s;    // a new command is latched at this edge
  logic       rdy_s;       // ready from the selected slave
  logic [7:0] prdata_s;    // read data from the selected slave
  logic       expire_s;    // stalled ACCESS has hit its limit

  logic       psel1_s;
  logic       psel2_s;
  logic       penable_s;
  logic       pwrite_s;
  logic [7:0] paddr_s;
  logic [7:0] pwdata_s;
  logic [7:0] rdata_s;
  logic       done_s;
  logic       busy_s;
  logic       err_s;

  // The unselected slave is ignored entirely.
  assign rdy_s    = sel2_r ? PREADY2 : PREADY1;
  assign prdata_s = sel2_r ? PRDATA2 : PRDATA1;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;

  // The stall that would make the count reach TIMEOUT ends the transfer.
  assign expire_s = (state_r == ST_ACCESS) && !rdy_s && (cnt_r == CNT_LAST);

  // Next stall count: cleared on entry to SETUP, +1 per stalled ACCESS edge.
  always_comb begin
    cnt_s = cnt_r;
    if (accept_s) begin
      cnt_s = {CNT_W{1'b0}};
    end else if ((state_r == ST_ACCESS) && !rdy_s && !expire_s) begin
      cnt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Stall counter register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_s;
    end
  end
`else
  // TIMEOUT has no effect in this build; ACCESS never expires.
  logic timeout_unused_s;
  assign timeout_unused_s = (TIMEOUT > 0);
  assign expire_s         = 1'b0;
`endif

  // Next-state and next-output decode; every register holds unless changed here.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    rdata_s  = rdata;
    done_s   = 1'b0;
    err_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (req) begin
          accept_s = 1'b1;
          state_s  = ST_SETUP;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_s = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (rdy_s) begin
          done_s = 1'b1;
          if (PWRITE) begin
            rdata_s = rdata;
          end else begin
            rdata_s = prdata_s;
          end
          if (req) begin
            accept_s = 1'b1;
            state_s  = ST_SETUP;
          end else begin
            state_s  = ST_IDLE;
          end
        end else if (expire_s) begin
          done_s  = 1'b1;
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ACCESS;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (accept_s) begin
      sel2_s   = addr[8];
      pwrite_s = wr;
      paddr_s  = addr[7:0];
      pwdata_s = wdata;
    end else begin
      sel2_s   = sel2_r;
      pwrite_s = PWRITE;
      paddr_s  = PADDR;
      pwdata_s = PWDATA;
    end

    busy_s    = (state_s != ST_IDLE);
    psel1_s   = busy_s & ~sel2_s;
    psel2_s   = busy_s & sel2_s;
    penable_s = (state_s == ST_ACCESS);
  end

  // FSM state and latched slave select.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r <= ST_IDLE;
      sel2_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      sel2_r  <= sel2_s;
    end
  end

  // Registered APB bus outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSEL1   <= 1'b0;
      PSEL2   <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= 8'h00;
      PWDATA  <= 8'h00;
    end else begin
      PSEL1   <= psel1_s;
      PSEL2   <= psel2_s;
      PENABLE <= penable_s;
      PWRITE  <= pwrite_s;
      PADDR   <= paddr_s;
      PWDATA  <= pwdata_s;
    end
  end

  // Registered local status outputs and captured read data.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rdata <= 8'h00;
      done  <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      rdata <= rdata_s;
      done  <= done_s;
      busy  <= busy_s;
      err   <= err_s;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized and directed bench for apb_master with two
// bench-side slave memories and a transaction-level reference model.
// Build with APB_MASTER_TIMEOUT_EN defined to exercise the timeout abort.
module tb_apb_master;

  localparam int TMO = 15;

  logic       PCLK    = 1'b0;
  logic       PRESETn = 1'b1;
  logic       req     = 1'b0;
  logic       wr      = 1'b0;
  logic [8:0] addr    = 9'h000;
  logic [7:0] wdata   = 8'h00;
  logic [7:0] rdata;
  logic       done, busy, err;
  logic       PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic [7:0] PRDATA1, PRDATA2;
  logic       PREADY1 = 1'b0;
  logic       PREADY2 = 1'b0;

  int   total = 0;
  int   bad   = 0;
  logic chk_en    = 1'b0;
  logic rand_mode = 1'b0;
  logic force1    = 1'b0;
  int   wait1 = 0;
  int   wait2 = 0;

  apb_master #(.TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req(req), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .done(done), .busy(busy), .err(err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2),
    .PREADY1(PREADY1), .PREADY2(PREADY2)
  );

  always #5 PCLK = ~PCLK;

  // ---------------- slave memories ----------------
  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];
  logic       mem_init = 1'b0;

  // Slaves store a write on the completing ACCESS edge; contents survive reset.
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      if (!mem_init) begin
        for (int i = 0; i < 256; i++) begin
          mem1[i] <= 8'(i) ^ 8'h5A;
          mem2[i] <= 8'(i) ^ 8'hC3;
        end
        mem_init <= 1'b1;
      end
    end else begin
      if (PSEL1 && PENABLE && PWRITE && PREADY1) mem1[PADDR] <= PWDATA;
      if (PSEL2 && PENABLE && PWRITE && PREADY2) mem2[PADDR] <= PWDATA;
    end
  end

  assign PRDATA1 = force1 ? 8'hFF : mem1[PADDR];
  assign PRDATA2 = mem2[PADDR];

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       w;
    logic [8:0] a;
    logic [7:0] d;
  } cmd_t;

  int         m_phase = 0;   // 0 idle, 1 setup, 2 access
  cmd_t       m_cmd   = '0;
  logic [7:0] m_rdata = 8'h00;
  logic       m_done  = 1'b0;
  logic       m_err   = 1'b0;
  int         m_wait  = 0;   // stalled ACCESS edges of the current transfer
  logic [7:0] ref1 [256];
  logic [7:0] ref2 [256];
  logic       ref_init = 1'b0;

  // Transaction-level model of a transfer and of the slave contents.
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      m_phase <= 0;
      m_cmd   <= '0;
      m_rdata <= 8'h00;
      m_done  <= 1'b0;
      m_err   <= 1'b0;
      m_wait  <= 0;
      if (!ref_init) begin
        for (int i = 0; i < 256; i++) begin
          ref1[i] <= 8'(i) ^ 8'h5A;
          ref2[i] <= 8'(i) ^ 8'hC3;
        end
        ref_init <= 1'b1;
      end
    end else begin
      m_done <= 1'b0;
      m_err  <= 1'b0;
      if (m_phase == 0) begin
        if (req) begin
          m_cmd   <= {wr, addr, wdata};
          m_phase <= 1;
        end
      end else if (m_phase == 1) begin
        m_phase <= 2;
        m_wait  <= 0;
      end else if (m_cmd.a[8] ? PREADY2 : PREADY1) begin
        m_done <= 1'b1;
        if (m_cmd.w) begin
          if (m_cmd.a[8]) ref2[m_cmd.a[7:0]] <= m_cmd.d;
          else            ref1[m_cmd.a[7:0]] <= m_cmd.d;
        end else begin
          m_rdata <= m_cmd.a[8] ? ref2[m_cmd.a[7:0]] : ref1[m_cmd.a[7:0]];
        end
        if (req) begin
          m_cmd   <= {wr, addr, wdata};
          m_phase <= 1;
        end else begin
          m_phase <= 0;
        end
      end else begin
        m_wait <= m_wait + 1;
`ifdef APB_MASTER_TIMEOUT_EN
        if (m_wait + 1 == TMO) begin
          m_done  <= 1'b1;
          m_err   <= 1'b1;
          m_phase <= 0;
        end
`endif
      end
    end
  end

  // Slave ready driver: random, or ready after waitN stalled ACCESS cycles.
  always @(negedge PCLK) begin
    if (rand_mode) begin
      PREADY1 <= ($urandom_range(9) < 32'd6);
      PREADY2 <= ($urandom_range(9) < 32'd6);
    end else begin
      PREADY1 <= (m_wait >= wait1);
      PREADY2 <= (m_wait >= wait2);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare of DUT outputs against the model.
  initial begin
    forever begin
      @(negedge PCLK);
      if (chk_en) begin
        chk("busy",    busy,    32'(m_phase != 0));
        chk("psel1",   PSEL1,   32'((m_phase != 0) && !m_cmd.a[8]));
        chk("psel2",   PSEL2,   32'((m_phase != 0) && m_cmd.a[8]));
        chk("penable", PENABLE, 32'(m_phase == 2));
        chk("done",    done,    32'(m_done));
        chk("err",     err,     32'(m_err));
        chk("rdata",   rdata,   32'(m_rdata));
        if (m_phase != 0) begin
          chk("pwrite", PWRITE, 32'(m_cmd.w));
          chk("paddr",  PADDR,  32'(m_cmd.a[7:0]));
          chk("pwdata", PWDATA, 32'(m_cmd.d));
        end
      end
    end
  end

  // One transfer from idle; returns cycles until done (SETUP counts as 1).
  task automatic do_xfer(input logic w, input logic [8:0] a, input logic [7:0] d,
                         input int max_cyc, output int cyc, output logic got,
                         output logic [7:0] setup_paddr);
    req = 1'b1; wr = w; addr = a; wdata = d;
    @(negedge PCLK);
    req = 1'b0;
    setup_paddr = PADDR;
    cyc = 1;
    got = 1'b0;
    while (!got && cyc < max_cyc) begin
      @(negedge PCLK);
      cyc++;
      if (done) got = 1'b1;
    end
  endtask

  int         cyc;
  logic       got;
  logic [7:0] pa;
  int         n_acc, n_done, busy_low;
  int         dcyc [3];

  initial begin
    #2 PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("reset_state", {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, rdata, done, busy, err}, 32'd0);
    #2 PRESETn = 1'b1;
    chk_en = 1'b1;
    @(negedge PCLK);

    // Write 0xA5 to slave1 address 0x05.
    req = 1'b1; wr = 1'b1; addr = 9'h005; wdata = 8'hA5;
    @(negedge PCLK);
    req = 1'b0;
    chk("wr1_setup_psel1", PSEL1, 32'd1);
    chk("wr1_setup_psel2", PSEL2, 32'd0);
    chk("wr1_setup_pen",   PENABLE, 32'd0);
    chk("wr1_paddr",       PADDR, 32'h05);
    chk("wr1_pwdata",      PWDATA, 32'hA5);
    @(negedge PCLK);
    chk("wr1_access_pen",  PENABLE, 32'd1);
    chk("wr1_access_psel1", PSEL1, 32'd1);
    @(negedge PCLK);
    chk("wr1_done", done, 32'd1);
    chk("wr1_idle", busy, 32'd0);

    // Read it back.
    do_xfer(1'b0, 9'h005, 8'h00, 10, cyc, got, pa);
    chk("rd1_got",   got, 32'd1);
    chk("rd1_cyc",   cyc, 32'd3);
    chk("rd1_rdata", rdata, 32'hA5);
    chk("rd1_err",   err, 32'd0);

    // Slave2 decode with slave1 data forced to 0xFF.
    force1 = 1'b1;
    do_xfer(1'b1, 9'h10A, 8'h3C, 10, cyc, got, pa);
    chk("wr2_paddr", pa, 32'h0A);
    chk("wr2_cyc",   cyc, 32'd3);
    do_xfer(1'b0, 9'h10A, 8'h00, 10, cyc, got, pa);
    chk("rd2_rdata", rdata, 32'h3C);
    force1 = 1'b0;

    // Three back-to-back writes, second one stalled 3 cycles.
    wait1 = 0; n_acc = 0; n_done = 0; busy_low = 0;
    req = 1'b1; wr = 1'b1; addr = 9'h020; wdata = 8'h11;
    for (int c = 1; c <= 40 && n_done < 3; c++) begin
      @(negedge PCLK);
      if (m_phase == 1) begin
        n_acc++;
        if (n_acc == 2) wait1 = 3;
        if (n_acc == 3) wait1 = 0;
        if (n_acc == 1) begin addr = 9'h021; wdata = 8'h22; end
        else if (n_acc == 2) begin addr = 9'h022; wdata = 8'h33; end
        else req = 1'b0;
      end
      if (done) begin dcyc[n_done] = c; n_done++; end
      if (!busy && n_done < 3) busy_low++;
    end
    chk("b2b_dones", n_done, 32'd3);
    chk("b2b_gap1",  dcyc[1] - dcyc[0], 32'd5);
    chk("b2b_gap2",  dcyc[2] - dcyc[1], 32'd2);
    chk("b2b_no_idle", busy_low, 32'd0);
    do_xfer(1'b0, 9'h021, 8'h00, 10, cyc, got, pa);
    chk("b2b_readback", rdata, 32'h22);

    // Slave2 never ready.
    wait2 = 255;
`ifdef APB_MASTER_TIMEOUT_EN
    do_xfer(1'b0, 9'h1F0, 8'h00, 40, cyc, got, pa);
    chk("tmo_done",   got, 32'd1);
    chk("tmo_cycles", cyc, 32'd17);
    chk("tmo_err",    err, 32'd1);
    chk("tmo_rdata",  rdata, 32'h22);
    chk("tmo_idle",   busy, 32'd0);
    wait2 = 0;
`else
    do_xfer(1'b0, 9'h1F0, 8'h00, 42, cyc, got, pa);
    chk("stall_nodone",  got, 32'd0);
    chk("stall_busy",    busy, 32'd1);
    chk("stall_penable", PENABLE, 32'd1);
    wait2 = 0;
    got = 1'b0;
    for (int c = 0; c < 5 && !got; c++) begin
      @(negedge PCLK);
      if (done) got = 1'b1;
    end
    chk("stall_release", got, 32'd1);
    chk("stall_rdata",   rdata, 32'h33);
`endif

    // Reset during a stalled read.
    wait1 = 255;
    req = 1'b1; wr = 1'b0; addr = 9'h005;
    @(negedge PCLK);
    req = 1'b0;
    repeat (4) @(negedge PCLK);
    chk("rst_pre_pen", PENABLE, 32'd1);
    #2 PRESETn = 1'b0;
    #1;
    chk("rst_outputs", {PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA, rdata, done, busy, err}, 32'd0);
    @(negedge PCLK);
    chk("rst_no_done", done, 32'd0);
    #2 PRESETn = 1'b1;
    wait1 = 0;
    @(negedge PCLK);
    do_xfer(1'b0, 9'h005, 8'h00, 10, cyc, got, pa);
    chk("rst_rd_cyc",   cyc, 32'd3);
    chk("rst_rd_rdata", rdata, 32'hA5);

    // Randomized traffic with random ready on both slaves.
    rand_mode = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge PCLK);
      req   = ($urandom_range(9) < 32'd7);
      wr    = 1'($urandom);
      addr  = {1'($urandom), 4'h0, 4'($urandom)};
      wdata = 8'($urandom);
    end
    @(negedge PCLK);
    req = 1'b0;
    rand_mode = 1'b0;
    for (int c = 0; c < 40 && busy; c++) @(negedge PCLK);
    chk("drain_idle", busy, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
